// File: rtl/port_allocator_if.sv
// port_allocator_if: request/release inputs and grant/ownership outputs of the output-port allocator
interface port_allocator_if #(
  parameter int PORTS = 4,
  parameter int DIR_W = 2
);
  logic [PORTS-1:0]       req_i;
  logic [PORTS*DIR_W-1:0] dest_i;
  logic [PORTS-1:0]       rel_i;
  logic [PORTS-1:0]       gnt_o;
  logic [PORTS-1:0]       hold_o;
  logic [PORTS-1:0]       out_busy_o;
  logic [PORTS*DIR_W-1:0] out_owner_o;
  logic [PORTS-1:0]       loopback_o;
  modport master (
    output req_i, dest_i, rel_i,
    input  gnt_o, hold_o, out_busy_o, out_owner_o, loopback_o
  );
  modport slave (
    input  req_i, dest_i, rel_i,
    output gnt_o, hold_o, out_busy_o, out_owner_o, loopback_o
  );
endinterface

// File: rtl/port_allocator.sv
// port_allocator: per-output round-robin FREE/OWNED allocator holding ownership until the owner releases
module port_allocator #(
  parameter int PORTS          = 4,
  parameter int DIR_W          = 2,
  parameter bit ALLOW_LOOPBACK = 1'b0
) (
  input logic clk,
  input logic rst,
  port_allocator_if.slave bus
);
  typedef enum logic {FREE, OWNED} state_t;
  state_t           st_q  [PORTS];
  state_t           st_d  [PORTS];
  logic [DIR_W-1:0] own_q [PORTS];
  logic [DIR_W-1:0] own_d [PORTS];
  logic [DIR_W-1:0] ptr_q [PORTS];
  logic [DIR_W-1:0] ptr_d [PORTS];
  logic [PORTS-1:0] cand  [PORTS];
  logic [PORTS-1:0] gnt_q, gnt_d, loop_q, loop_d, hold, busy;
  always_comb begin
    logic             found;
    logic [DIR_W-1:0] w, idx;
    hold   = '0;
    busy   = '0;
    gnt_d  = '0;
    loop_d = '0;
    found  = 1'b0;
    w      = '0;
    idx    = '0;
    for (int j = 0; j < PORTS; j++) begin
      busy[j] = st_q[j] == OWNED;
      if (busy[j]) hold[own_q[j]] = 1'b1;
    end
    for (int i = 0; i < PORTS; i++) begin
      loop_d[i] = !ALLOW_LOOPBACK && bus.req_i[i] && !hold[i] && bus.dest_i[i*DIR_W +: DIR_W] == DIR_W'(i);
      for (int j = 0; j < PORTS; j++)
        cand[j][i] = bus.req_i[i] && !hold[i] && bus.dest_i[i*DIR_W +: DIR_W] == DIR_W'(j) && (ALLOW_LOOPBACK || i != j);
    end
    for (int j = 0; j < PORTS; j++) begin
      st_d[j]  = st_q[j];
      own_d[j] = own_q[j];
      ptr_d[j] = ptr_q[j];
      found    = 1'b0;
      w        = '0;
      if (st_q[j] == FREE) begin
        for (int k = 0; k < PORTS; k++) begin
          idx = ptr_q[j] + DIR_W'(k);
          if (!found && cand[j][idx]) begin
            found = 1'b1;
            w     = idx;
          end
        end
        if (found) begin
          st_d[j]  = OWNED;
          own_d[j] = w;
          ptr_d[j] = w + 1'b1;
          gnt_d[w] = 1'b1;
        end
      end else if (bus.rel_i[own_q[j]]) begin
        st_d[j]  = FREE;
        own_d[j] = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < PORTS; j++) begin
        st_q[j]  <= FREE;
        own_q[j] <= '0;
        ptr_q[j] <= '0;
      end
      gnt_q  <= '0;
      loop_q <= '0;
    end else begin
      for (int j = 0; j < PORTS; j++) begin
        st_q[j]  <= st_d[j];
        own_q[j] <= own_d[j];
        ptr_q[j] <= ptr_d[j];
      end
      gnt_q  <= gnt_d;
      loop_q <= loop_d;
    end
  end
  assign bus.gnt_o      = gnt_q;
  assign bus.loopback_o = loop_q;
  assign bus.hold_o     = hold;
  assign bus.out_busy_o = busy;
  for (genvar g = 0; g < PORTS; g++) begin : g_own
    assign bus.out_owner_o[g*DIR_W +: DIR_W] = own_q[g];
  end
endmodule

// File: tb/tb_port_allocator.sv
// tb_port_allocator: scoreboard bench comparing two allocators (loopback off/on) against an ownership-table model
module tb_port_allocator;
  localparam int P = 4;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  port_allocator_if #(.PORTS(P), .DIR_W(W)) b0 ();
  port_allocator_if #(.PORTS(P), .DIR_W(W)) b1 ();
  port_allocator #(.PORTS(P), .DIR_W(W), .ALLOW_LOOPBACK(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  port_allocator #(.PORTS(P), .DIR_W(W), .ALLOW_LOOPBACK(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] hold;
    logic [3:0] busy;
    logic [7:0] owner;
    logic [3:0] loop;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int own [2][4];
  int ptr [2][4];
  int checks = 0;
  int errors = 0;
  int gseq[$];
  bit rec = 1'b0;
  function automatic logic [7:0] dv(int a, int b, int c, int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction
  function automatic void cmp(string nm, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endfunction
  function automatic void inv(string nm, logic [3:0] hold, logic [3:0] busy, logic [7:0] owner);
    bit ok;
    int cnt;
    ok = $countones(hold) == $countones(busy);
    for (int i = 0; i < P; i++) begin
      cnt = 0;
      for (int j = 0; j < P; j++)
        if (busy[j] && owner[j*W +: W] == 2'(i)) cnt++;
      if (hold[i] && cnt != 1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s invariant actual hold=%b busy=%b owner=%h required one owned output per holder", nm, hold, busy, owner);
    end
  endfunction
  task automatic model_step(int m, logic r, logic [3:0] rq, logic [7:0] ds, logic [3:0] rl, output exp_t e);
    int  nown [4];
    bit  held [4];
    bit  allow;
    int  i;
    allow = (m == 1);
    e = '0;
    if (r) begin
      for (int j = 0; j < P; j++) begin
        own[m][j] = -1;
        ptr[m][j] = 0;
      end
      return;
    end
    for (int k = 0; k < P; k++) held[k] = 1'b0;
    for (int j = 0; j < P; j++) if (own[m][j] >= 0) held[own[m][j]] = 1'b1;
    for (int k = 0; k < P; k++)
      if (!allow && rq[k] && !held[k] && ds[k*W +: W] == 2'(k)) e.loop[k] = 1'b1;
    for (int j = 0; j < P; j++) begin
      nown[j] = own[m][j];
      if (own[m][j] < 0) begin
        for (int k = 0; k < P; k++) begin
          i = (ptr[m][j] + k) % P;
          if (rq[i] && ds[i*W +: W] == 2'(j) && !held[i] && (allow || i != j)) begin
            nown[j] = i;
            ptr[m][j] = (i + 1) % P;
            e.gnt[i] = 1'b1;
            break;
          end
        end
      end else if (rl[own[m][j]]) begin
        nown[j] = -1;
      end
    end
    for (int j = 0; j < P; j++) begin
      own[m][j] = nown[j];
      if (nown[j] >= 0) begin
        e.busy[j] = 1'b1;
        e.hold[nown[j]] = 1'b1;
        e.owner[j*W +: W] = 2'(nown[j]);
      end
    end
  endtask
  task automatic drive(logic r, logic [3:0] rq, logic [7:0] ds, logic [3:0] rl);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r;
    b0.req_i = rq; b0.dest_i = ds; b0.rel_i = rl;
    b1.req_i = rq; b1.dest_i = ds; b1.rel_i = rl;
    model_step(0, r, rq, ds, rl, e);
    q0.push_back(e);
    model_step(1, r, rq, ds, rl, e);
    q1.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("gnt0", 8'(b0.gnt_o), 8'(e.gnt));
      cmp("hold0", 8'(b0.hold_o), 8'(e.hold));
      cmp("busy0", 8'(b0.out_busy_o), 8'(e.busy));
      cmp("owner0", b0.out_owner_o, e.owner);
      cmp("loop0", 8'(b0.loopback_o), 8'(e.loop));
      inv("dut0", b0.hold_o, b0.out_busy_o, b0.out_owner_o);
      if (rec) for (int i = 0; i < P; i++) if (b0.gnt_o[i]) gseq.push_back(i);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("gnt1", 8'(b1.gnt_o), 8'(e.gnt));
      cmp("hold1", 8'(b1.hold_o), 8'(e.hold));
      cmp("busy1", 8'(b1.out_busy_o), 8'(e.busy));
      cmp("owner1", b1.out_owner_o, e.owner);
      cmp("loop1", 8'(b1.loopback_o), 8'(e.loop));
      inv("dut1", b1.hold_o, b1.out_busy_o, b1.out_owner_o);
    end
  end
  initial begin
    int hc;
    int ord [5];
    logic [3:0] rq, rl;
    logic [7:0] ds;
    ord = '{0, 1, 2, 0, 1};
    rst = 1'b1;
    b0.req_i = '0; b0.dest_i = '0; b0.rel_i = '0;
    b1.req_i = '0; b1.dest_i = '0; b1.rel_i = '0;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 4'b0100, dv(0, 0, 3, 0), 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 4'b0100);
    drive(0, 0, 0, 0);
    rec = 1'b1;
    hc = 0;
    for (int n = 0; n < 60 && gseq.size() < 5; n++) begin
      hc = (own[0][3] >= 0) ? hc + 1 : 0;
      rl = (hc == 3) ? 4'(1 << own[0][3]) : 4'b0;
      drive(0, 4'b0111, dv(3, 3, 3, 0), rl);
    end
    rec = 1'b0;
    drive(0, 0, 0, 4'b1111);
    drive(0, 0, 0, 0);
    checks++;
    if (gseq.size() < 5) begin
      errors++;
      $display("FAIL rr_order actual grants=%0d required 5", gseq.size());
    end else begin
      for (int i = 0; i < 5; i++) cmp("rr_order", 8'(gseq[i]), 8'(ord[i]));
    end
    drive(0, 4'b0101, dv(1, 0, 3, 0), 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 4'b0101);
    for (int n = 0; n < 4; n++) drive(0, 4'b0010, dv(0, 1, 0, 0), 0);
    drive(0, 0, 0, 4'b0010);
    drive(0, 0, 0, 0);
    drive(0, 4'b1000, dv(0, 0, 0, 0), 0);
    drive(0, 0, 0, 0);
    drive(0, 4'b1010, dv(0, 0, 0, 0), 4'b1000);
    drive(0, 4'b0010, dv(0, 0, 0, 0), 0);
    drive(0, 4'b0010, dv(0, 0, 0, 0), 0);
    drive(0, 0, 0, 4'b0010);
    drive(0, 4'b0101, dv(1, 0, 3, 0), 0);
    drive(0, 0, 0, 0);
    drive(1, 4'b1010, dv(0, 2, 0, 1), 0);
    drive(0, 4'b0010, dv(0, 2, 0, 0), 0);
    drive(0, 0, 0, 4'b1111);
    for (int n = 0; n < 2000; n++) begin
      rq = '0; rl = '0; ds = '0;
      for (int i = 0; i < P; i++) begin
        bit h;
        h = 1'b0;
        for (int j = 0; j < P; j++) if (own[0][j] == i) h = 1'b1;
        rq[i] = ($urandom % 4) != 0;
        ds[i*W +: W] = 2'($urandom % P);
        rl[i] = h ? ($urandom % 4) == 0 : ($urandom % 8) == 0;
      end
      drive(($urandom % 100) == 0, rq, ds, rl);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d required=0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/port_allocator.md
# port_allocator

Per-router output-port allocator for the 4-port mesh node. Each input port requests one output direction (NORTH/SOUTH/EAST/WEST). The block grants each free output to at most one input with a per-output round-robin pointer, and holds that ownership until the owning input releases it. It sits between the node's per-input routing FSMs and the crossbar: its owner table drives crossbar destination selection.

## Interface
Parameters:
- PORTS, 4, number of router ports; direction index i equals port index i.
- DIR_W, 2, width of a direction index (clog2(PORTS)).
- ALLOW_LOOPBACK, 0, when 0, a request with dest_i[i] == i is never granted.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  PORTS  input i requests an output this cycle; level, held until granted or abandoned.
- dest_i  in  PORTS*DIR_W  requested output of input i, at bits [i*DIR_W +: DIR_W].
- rel_i  in  PORTS  input i releases the output it owns (tail passed or downstream reject).
- gnt_o  out  PORTS  registered one-cycle grant pulse to input i.
- hold_o  out  PORTS  input i currently owns an output.
- out_busy_o  out  PORTS  output j currently owned.
- out_owner_o  out  PORTS*DIR_W  owning input of output j, at bits [j*DIR_W +: DIR_W]; 0 when not busy.
- loopback_o  out  PORTS  registered pulse: input i requested its own direction while ALLOW_LOOPBACK=0.

## Operation
- Each output j has a two-state FSM, FREE or OWNED, plus a round-robin pointer ptr[j] of DIR_W bits.
- Candidate for output j: input i with req_i[i]=1, dest_i[i]==j, hold_o[i]=0, and not (ALLOW_LOOPBACK=0 and i==j).
- FREE with at least one candidate:
  - Winner w is the first candidate found scanning i = ptr[j], ptr[j]+1, … modulo PORTS.
  - Next state is OWNED, with owner=w, gnt_o[w]=1 for one cycle, and hold_o[w]=1.
  - ptr[j] is set to (w+1) mod PORTS, wrapping from PORTS-1 to 0.
- FREE with no candidate: state and ptr unchanged.
- OWNED with rel_i[owner]=1: next state is FREE, hold_o[owner]=0, out_busy_o[j]=0, and out_owner_o field goes to 0. ptr is unchanged.
- OWNED, otherwise: state is held. Requests from other inputs to output j are ignored and are not queued; requesters keep req asserted.
- An input can win at most one output, because it has a single dest. Different outputs arbitrate independently and may grant in the same cycle.
- req_i from an input that already holds an output is ignored.
- rel_i from an input that holds nothing is ignored.
- req_i and rel_i asserted together by an owner: the release takes effect, and the request is evaluated no earlier than the next cycle.
- dest_i changing while ungranted: arbitration uses the value sampled on the current edge only.
- Loopback request with ALLOW_LOOPBACK=0: loopback_o[i] pulses each cycle the request is sampled; there is no grant.
- Invariant (assert in bench): at most one output has out_owner_o==i while hold_o[i]=1, and hold_o has exactly popcount(out_busy_o) bits set.

## Timing
- Reset (rst high at a rising edge) sets all FSMs to FREE and all ptr to 0. gnt_o, hold_o, out_busy_o, out_owner_o and loopback_o all become 0.
- rst has priority over every other input. Reset mid-packet drops all ownership with no release handshake.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Grant latency: req_i sampled at edge t gives gnt_o, hold_o, out_busy_o and out_owner_o valid in cycle t+1.
- Release latency: rel_i sampled at edge t clears out_busy_o in cycle t+1.
- Re-grant: the earliest new grant of a released output is cycle t+2, which requires a request sampled at edge t+1. There is no same-edge release-and-grant.
- Loopback flag: loopback_o is asserted in cycle t+1 for a request sampled at edge t.

## Test plan
- Reset, then input 2 requests EAST (3) → gnt_o=0100 for exactly one cycle. hold_o[2]=1, out_busy_o[3]=1, out_owner[3]=2, ptr[3]=3.
- Inputs 0, 1 and 2 all request output 3 continuously, each releasing 3 cycles after its grant → grant order is 0,1,2,0,1. Each re-grant arrives exactly 2 cycles after the previous release.
- Input 0 requests 1 and input 2 requests 3 in the same cycle → both granted in the same cycle: gnt_o=0101, out_busy_o=1010.
- Input 1 requests output 1 with ALLOW_LOOPBACK=0 for 4 cycles → no grant, loopback_o[1]=1 for 4 cycles; the same test with ALLOW_LOOPBACK=1 → granted.
- Input 3 owns output 0; input 3 asserts req+rel while input 1 requests 0 → busy drops next cycle, then input 1 is granted. Ptr[0] was 0 after input 3's grant, so input 1 is the first candidate.
- rst asserted while two outputs are OWNED → next cycle all outputs are 0. A request in the following cycle is granted with ptr back at 0.
